// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse types and constants for the encoder/decoder pair
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2
  } morse_state_e;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;

  localparam int unsigned DEF_UNIT_CYCLES      = 1000;
  localparam int unsigned DEF_DASH_UNITS       = 2;
  localparam int unsigned DEF_LETTER_GAP_UNITS = 2;
  localparam int unsigned DEF_WORD_GAP_UNITS   = 5;

endpackage

// File: rtl/morse_decoder_if.sv
// rtl/morse_decoder_if.sv - decoded character output bundle of the Morse decoder
interface morse_decoder_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_err;
  logic       busy;

  modport master (output char_out, output char_valid, output char_err, output busy);
  modport slave  (input char_out, input char_valid, input char_err, input busy);
endinterface

// File: rtl/morse_lookup.sv
// rtl/morse_lookup.sv - (pattern, length) to uppercase ASCII, inverse of the encoder table
module morse_lookup
  import morse_pkg::*;
(
  input  logic [7:0] pattern,
  input  logic [2:0] length,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [7:0] code;

  // Upper pattern bits take part in the match, so stale high bits never alias a letter.
  always_comb begin
    code = 8'h00;
    case ({length, pattern})
      {3'd1, 8'b0}:    code = "E";
      {3'd1, 8'b1}:    code = "T";
      {3'd2, 8'b00}:   code = "I";
      {3'd2, 8'b01}:   code = "A";
      {3'd2, 8'b10}:   code = "N";
      {3'd2, 8'b11}:   code = "M";
      {3'd3, 8'b000}:  code = "S";
      {3'd3, 8'b001}:  code = "U";
      {3'd3, 8'b010}:  code = "R";
      {3'd3, 8'b011}:  code = "W";
      {3'd3, 8'b100}:  code = "D";
      {3'd3, 8'b101}:  code = "K";
      {3'd3, 8'b110}:  code = "G";
      {3'd3, 8'b111}:  code = "O";
      {3'd4, 8'b0000}: code = "H";
      {3'd4, 8'b0001}: code = "V";
      {3'd4, 8'b0010}: code = "F";
      {3'd4, 8'b0100}: code = "L";
      {3'd4, 8'b0110}: code = "P";
      {3'd4, 8'b0111}: code = "J";
      {3'd4, 8'b1000}: code = "B";
      {3'd4, 8'b1001}: code = "X";
      {3'd4, 8'b1010}: code = "C";
      {3'd4, 8'b1011}: code = "Y";
      {3'd4, 8'b1100}: code = "Z";
      {3'd4, 8'b1101}: code = "Q";
      default:         code = 8'h00;
    endcase
  end

  assign valid = (code != 8'h00);
  assign ascii = valid ? code : CHAR_UNKNOWN;

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - times key marks/spaces and emits decoded ASCII characters
// Optional MORSE_DEC_SYNC_EN adds a 2-flop synchronizer on key_in.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = DEF_UNIT_CYCLES,
  parameter int unsigned DASH_UNITS       = DEF_DASH_UNITS,
  parameter int unsigned LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
  parameter int unsigned WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in,
  morse_decoder_if.master  char_if
);

  localparam int unsigned RUN_MAX = WORD_GAP_UNITS * UNIT_CYCLES;
  localparam int          RW      = $clog2(RUN_MAX + 1);
  localparam logic [RW-1:0] RUN_SAT   = RW'(RUN_MAX);
  localparam logic [RW-1:0] DASH_TH   = RW'(DASH_UNITS * UNIT_CYCLES);
  localparam logic [RW-1:0] LETTER_TH = RW'(LETTER_GAP_UNITS * UNIT_CYCLES);

  morse_state_e  state;
  logic          key_s;
  logic          key_q;
  logic [RW-1:0] run;
  logic [RW-1:0] run_now;
  logic [7:0]    pattern;
  logic [2:0]    count;
  logic          overflow;
  logic          word_pend;
  logic          sym;
  logic [7:0]    lk_ascii;
  logic          lk_valid;

`ifdef MORSE_DEC_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign key_s = sync_q[1];
`else
  assign key_s = key_in;
`endif

  // Length of the current level including this cycle; a level change restarts at 1.
  always_comb begin
    run_now = run;
    if (key_s != key_q) begin
      run_now = RW'(1);
    end else if (run != RUN_SAT) begin
      run_now = run + RW'(1);
    end
  end

  // In MARK the falling-edge cycle still sees the completed mark length in run.
  assign sym = (run >= DASH_TH) ? DASH : DOT;

  morse_lookup u_lookup (
    .pattern (pattern),
    .length  (count),
    .ascii   (lk_ascii),
    .valid   (lk_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      key_q              <= 1'b0;
      run                <= '0;
      pattern            <= 8'h00;
      count              <= 3'd0;
      overflow           <= 1'b0;
      word_pend          <= 1'b0;
      char_if.char_out   <= 8'h00;
      char_if.char_valid <= 1'b0;
      char_if.char_err   <= 1'b0;
      char_if.busy       <= 1'b0;
    end else begin
      key_q              <= key_s;
      run                <= run_now;
      char_if.char_valid <= 1'b0;
      char_if.char_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_s) begin
            state        <= ST_MARK;
            char_if.busy <= 1'b1;
          end
        end
        ST_MARK: begin
          if (!key_s) begin
            if (count >= 3'd4) begin
              overflow <= 1'b1;
              count    <= 3'd5;
            end else begin
              pattern <= {pattern[6:0], sym};
              count   <= count + 3'd1;
            end
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (key_s) begin
            state <= ST_MARK;
          end else if (run_now == LETTER_TH && count != 3'd0) begin
            char_if.char_out   <= overflow ? CHAR_UNKNOWN : lk_ascii;
            char_if.char_err   <= overflow || !lk_valid;
            char_if.char_valid <= 1'b1;
            pattern            <= 8'h00;
            count              <= 3'd0;
            overflow           <= 1'b0;
            word_pend          <= 1'b1;
          end else if (run_now == RUN_SAT) begin
            if (word_pend) begin
              char_if.char_out   <= CHAR_SPACE;
              char_if.char_valid <= 1'b1;
              word_pend          <= 1'b0;
            end
            state        <= ST_IDLE;
            char_if.busy <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          char_if.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - self-checking bench for morse_decoder (UNIT_CYCLES=4, no synchronizer)
module tb_morse_decoder;

  localparam int UNIT = 4;
  localparam int DASH_LEN = 2 * UNIT;
  localparam int LETTER_LEN = 2 * UNIT;
  localparam int WORD_LEN = 5 * UNIT;

  typedef struct {
    int         t;
    logic [7:0] ch;
    logic       err;
  } ev_t;

  typedef struct {
    int         nruns;
    int         runs[10];
    int         nexp;
    logic [7:0] ch[3];
    logic       err[3];
  } vec_t;

  logic clk;
  logic rst_n;
  logic key;
  int   cyc;
  int   checks;
  int   failures;
  ev_t  ev_q[$];
  ev_t  exp_q[$];
  vec_t vt[7];
  string codes[26];

  morse_decoder_if dif ();

  morse_decoder #(
    .UNIT_CYCLES      (UNIT),
    .DASH_UNITS       (2),
    .LETTER_GAP_UNITS (2),
    .WORD_GAP_UNITS   (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key),
    .char_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dif.char_valid) ev_q.push_back('{cyc, dif.char_out, dif.char_err});
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drives alternating mark/space runs starting with a mark; each level starts just after a rising edge.
  task automatic play(input int runs[$], output int base);
    ev_q.delete();
    base = cyc;
    for (int i = 0; i < runs.size(); i++) begin
      key = (i % 2 == 0);
      repeat (runs[i]) @(posedge clk);
      #1;
    end
    key = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference: symbols collected as a dot/dash string, decoded by searching the letter code table.
  function automatic void build_model(input int runs[$], input int base);
    string s;
    int    t;
    bit    wp;
    ev_t   e;
    exp_q.delete();
    s  = "";
    t  = base;
    wp = 0;
    for (int i = 0; i < runs.size(); i++) begin
      if (i % 2 == 0) begin
        if (runs[i] >= DASH_LEN) s = {s, "-"};
        else s = {s, "."};
      end else begin
        if (runs[i] >= LETTER_LEN && s.len() > 0) begin
          e.t   = t + LETTER_LEN;
          e.ch  = 8'h3F;
          e.err = 1'b1;
          if (s.len() <= 4) begin
            for (int k = 0; k < 26; k++) begin
              if (codes[k] == s) begin
                e.ch  = 8'h41 + 8'(k);
                e.err = 1'b0;
              end
            end
          end
          exp_q.push_back(e);
          s  = "";
          wp = 1;
        end
        if (runs[i] >= WORD_LEN && wp) begin
          e.t   = t + WORD_LEN;
          e.ch  = 8'h20;
          e.err = 1'b0;
          exp_q.push_back(e);
          wp = 0;
        end
      end
      t += runs[i];
    end
  endfunction

  task automatic compare(input string name);
    chk({name, " event_count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      chk($sformatf("%s ev%0d time", name, i), ev_q[i].t, exp_q[i].t);
      chk($sformatf("%s ev%0d char", name, i), ev_q[i].ch, exp_q[i].ch);
      chk($sformatf("%s ev%0d err", name, i), ev_q[i].err, exp_q[i].err);
    end
    chk({name, " busy_after"}, dif.busy, 1'b0);
  endtask

  initial begin
    int base;
    int busy_hi;
    int runs[$];
    int nlet;
    int nsym;
    checks   = 0;
    failures = 0;
    codes = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
              "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
              "..-", "...-", ".--", "-..-", "-.--", "--.."};

    vt[0] = '{4,  '{4, 4, 12, 24, 0, 0, 0, 0, 0, 0},    2, '{8'h41, 8'h20, 8'h00}, '{1'b0, 1'b0, 1'b0}};
    vt[1] = '{4,  '{7, 8, 8, 24, 0, 0, 0, 0, 0, 0},     3, '{8'h45, 8'h54, 8'h20}, '{1'b0, 1'b0, 1'b0}};
    vt[2] = '{10, '{4, 4, 4, 4, 4, 4, 4, 4, 4, 24},     2, '{8'h3F, 8'h20, 8'h00}, '{1'b1, 1'b0, 1'b0}};
    vt[3] = '{4,  '{4, 7, 4, 24, 0, 0, 0, 0, 0, 0},     2, '{8'h49, 8'h20, 8'h00}, '{1'b0, 1'b0, 1'b0}};
    vt[4] = '{6,  '{12, 4, 12, 4, 12, 24, 0, 0, 0, 0},  2, '{8'h4F, 8'h20, 8'h00}, '{1'b0, 1'b0, 1'b0}};
    vt[5] = '{8,  '{4, 4, 4, 4, 12, 4, 12, 24, 0, 0},   2, '{8'h3F, 8'h20, 8'h00}, '{1'b1, 1'b0, 1'b0}};
    vt[6] = '{2,  '{30, 20, 0, 0, 0, 0, 0, 0, 0, 0},    2, '{8'h54, 8'h20, 8'h00}, '{1'b0, 1'b0, 1'b0}};

    rst_n = 1'b0;
    key   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset char_out", dif.char_out, 8'h00);
    chk("reset char_valid", dif.char_valid, 1'b0);
    chk("reset char_err", dif.char_err, 1'b0);
    chk("reset busy", dif.busy, 1'b0);
    rst_n = 1'b1;

    ev_q.delete();
    busy_hi = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (dif.busy) busy_hi++;
    end
    chk("idle busy_cycles", busy_hi, 0);
    chk("idle event_count", ev_q.size(), 0);

    for (int v = 0; v < 7; v++) begin
      runs.delete();
      for (int i = 0; i < vt[v].nruns; i++) runs.push_back(vt[v].runs[i]);
      play(runs, base);
      build_model(runs, base);
      compare($sformatf("vec%0d", v));
      for (int k = 0; k < vt[v].nexp && k < ev_q.size(); k++) begin
        chk($sformatf("vec%0d table char%0d", v, k), ev_q[k].ch, vt[v].ch[k]);
        chk($sformatf("vec%0d table err%0d", v, k), ev_q[k].err, vt[v].err[k]);
      end
    end

    ev_q.delete();
    key = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    key = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    key = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midmark busy", dif.busy, 1'b1);
    rst_n = 1'b0;
    key   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midmark reset busy", dif.busy, 1'b0);
    chk("midmark reset char_out", dif.char_out, 8'h00);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("midmark no_char", ev_q.size(), 0);
    chk("midmark busy_after", dif.busy, 1'b0);
    runs = '{4, 24};
    play(runs, base);
    build_model(runs, base);
    compare("post_reset");
    if (ev_q.size() > 0) chk("post_reset first_char", ev_q[0].ch, 8'h45);

    for (int s = 0; s < 12; s++) begin
      runs.delete();
      nlet = $urandom_range(1, 3);
      for (int l = 0; l < nlet; l++) begin
        nsym = $urandom_range(1, 6);
        for (int k = 0; k < nsym; k++) begin
          if ($urandom_range(0, 1) == 1) runs.push_back(int'($urandom_range(8, 30)));
          else runs.push_back(int'($urandom_range(1, 7)));
          if (k < nsym - 1) runs.push_back(int'($urandom_range(1, 7)));
        end
        if (l < nlet - 1) begin
          if ($urandom_range(0, 1) == 1) runs.push_back(int'($urandom_range(8, 19)));
          else runs.push_back(int'($urandom_range(20, 30)));
        end else begin
          runs.push_back(24);
        end
      end
      play(runs, base);
      build_model(runs, base);
      compare($sformatf("rand%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side counterpart of the Morse character encoder. It samples a single on/off key line, times marks and spaces in clock cycles, and assembles dot/dash symbols into a pattern. The pattern uses the encoder's pattern/length convention: 0 = dot, 1 = dash, first symbol in the most significant of the `length` used bits. On a letter gap it emits the corresponding uppercase ASCII character, and on a word gap it emits a space. It sits between the key input pad (or loopback from the transmit keyer) and the character sink.

## Interface
- `UNIT_CYCLES`, 1000, clock cycles per Morse time unit (≥2)
- `DASH_UNITS`, 2, mark of ≥ DASH_UNITS·UNIT_CYCLES cycles is a dash, shorter is a dot
- `LETTER_GAP_UNITS`, 2, space length that terminates a letter
- `WORD_GAP_UNITS`, 5, space length that emits a word separator (> LETTER_GAP_UNITS)

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `key_in`  in  1  key line, 1 = mark (tone), 0 = space
- `char_out`  out  8  decoded ASCII; holds last value between pulses
- `char_valid`  out  1  one-cycle pulse, `char_out` valid; no backpressure
- `char_err`  out  1  pulses with `char_valid` when pattern is unknown or overflowed
- `busy`  out  1  high whenever FSM is not IDLE

## Operation
- Internal state: 8-bit pattern shift register, 3-bit symbol count, overflow flag, `word_pend` flag, saturating run counter. The run counter saturates at WORD_GAP_UNITS·UNIT_CYCLES and is reset on every level change of the sampled key.
- FSM states: IDLE, MARK, GAP.
  - IDLE: key=1 → MARK.
  - MARK: sampled falling edge → classify mark, then go to GAP. Classification: the run count is compared against DASH_UNITS·UNIT_CYCLES. The symbol is shifted into the pattern LSB (pattern ← {pattern[6:0], sym}) and the count is incremented.
  - GAP: key=1 before the letter threshold → MARK, same letter. At run = LETTER_GAP_UNITS·UNIT_CYCLES with count>0 → emit letter, clear pattern/count/overflow, set `word_pend`, stay in GAP. At run = WORD_GAP_UNITS·UNIT_CYCLES with `word_pend` → emit 0x20, clear `word_pend`, go to IDLE. When no emission is due, GAP → IDLE at the word threshold.
  - Key=1 in GAP after the letter was emitted → MARK; the new letter starts.
- Lookup covers A–Z with encoder-identical codes, length 1–4.
  - Unmatched pattern of length 1–4 → `char_out`=0x3F ('?'), `char_err`=1.
  - A 5th or later symbol sets overflow. Pattern stops shifting and count saturates at 5. At emission → 0x3F with `char_err`=1.
- Space is emitted at most once per gap. It is never emitted after reset or after a previous space without an intervening letter.
- A mark longer than the saturation value is still a dash. The FSM stays in MARK until the falling edge.

## Timing
- Reset values: `char_out`=0x00, `char_valid`=0, `char_err`=0, `busy`=0; FSM=IDLE, all counters and flags cleared.
- Reset asserted mid-letter discards the partial pattern; no character is emitted.
- Sample latency: key edge visible to the FSM 0 cycles after `key_in` (synchronizer off) or 2 cycles after (see Configuration).
- Run counting: the first cycle at the new level counts as 1.
- Letter emission: `char_valid` rises in the cycle after the (LETTER_GAP_UNITS·UNIT_CYCLES)-th consecutive sampled low cycle. Space emission follows the same rule at WORD_GAP_UNITS·UNIT_CYCLES.
- `char_valid` is high exactly 1 cycle per character. Letter and space are never in the same cycle.
- A key rising edge in the same cycle as a threshold hit: the emission occurs, and MARK is entered next cycle.

## Configuration
- `MORSE_DEC_SYNC_EN`
  - Defined: `key_in` passes through a 2-flop synchronizer (reset to 0) before edge detection; 2 cycles added latency.
  - Undefined: `key_in` is assumed synchronous to `clk` and sampled directly.

## Structure
- `morse_pkg`: FSM state enum, symbol constants DOT=1'b0/DASH=1'b1, ASCII constants CHAR_SPACE=8'h20 and CHAR_UNKNOWN=8'h3F, default threshold values. The package is shared with the encoder.
- Sub-module `morse_lookup`: combinational, (pattern[7:0], length[2:0]) → (ascii[7:0], valid). It is the exact inverse of the encoder table.

## Test plan
UNIT_CYCLES=4, synchronizer off, defaults otherwise.
- Mark 4, low 4, mark 12, low 24 → `char_out`=0x41 ('A') pulse 8 cycles after last fall; 0x20 pulse 20 cycles after the fall.
- Mark 7, low 8, mark 8, low 8 → 0x45 ('E') then 0x54 ('T'), `char_err`=0 both.
- Five marks of 4, separated by 4 low, then low 8 → `char_out`=0x3F, `char_err`=1, no lookup match.
- Mark 4, low 7, mark 4, low 8 → single 0x49 ('I'); the gap of 7 < 8 does not split the letter.
- Mark 4, low 4, mark 4, then `rst_n` low 3 cycles mid-mark → no `char_valid`, `busy`=0. A subsequent mark 4 + low 8 → 0x45.
- After reset, `key_in` held low 100 cycles → no `char_valid`, `busy` stays 0.
